// File: rtl/free_list_pkg.sv
// Shared types and sizing for the physical-register free list of the 2-wide
// rename stage.
package free_list_pkg;

    localparam int NUM_SUPER = 2;
    localparam int NUM_PR    = 64;
    localparam int NUM_FL    = 32;
    localparam int NUM_ROB   = 32;
    localparam int ZERO_REG  = 31;

    localparam int PR_W   = $clog2(NUM_PR);
    localparam int FL_W   = $clog2(NUM_FL);
    localparam int ROB_W  = $clog2(NUM_ROB);
    localparam int ARCH_W = 5;

    typedef logic [PR_W-1:0]   PR_IDX_t;
    typedef logic [ARCH_W-1:0] ARCH_IDX_t;
    typedef logic [ROB_W-1:0]  ROB_IDX_t;
    // Extended pointer: the MSB is a wrap bit, so full and empty differ.
    typedef logic [FL_W:0]     FL_PTR_t;

    typedef struct packed {
        PR_IDX_t [NUM_SUPER-1:0] T_idx;
    } FL_ROB_OUT_t;

    typedef struct packed {
        ARCH_IDX_t [NUM_SUPER-1:0] dest_idx;
    } DECODER_FL_OUT_t;

    typedef struct packed {
        PR_IDX_t [NUM_SUPER-1:0] Told_idx;
    } ROB_FL_OUT_t;

endpackage

// File: rtl/free_list_if.sv
// Dispatch / retire / rollback bundle between the pipeline (master) and the
// free list (slave).
interface free_list_if;
    import free_list_pkg::*;

    logic                      en;
    logic                      dispatch_en;
    DECODER_FL_OUT_t           decoder;
    ROB_IDX_t [NUM_SUPER-1:0]  ROB_idx;
    logic [NUM_SUPER-1:0]      retire_en;
    ROB_FL_OUT_t               rob;
    logic                      rollback_en;
    ROB_IDX_t                  ROB_rollback_idx;
    FL_ROB_OUT_t               fl;
    logic                      FL_valid;
    FL_PTR_t                   free_count;

    modport master (
        output en, dispatch_en, decoder, ROB_idx, retire_en, rob,
               rollback_en, ROB_rollback_idx,
        input  fl, FL_valid, free_count
    );

    modport slave (
        input  en, dispatch_en, decoder, ROB_idx, retire_en, rob,
               rollback_en, ROB_rollback_idx,
        output fl, FL_valid, free_count
    );

endinterface

// File: rtl/fl_ckpt.sv
// Per-ROB-entry snapshot of the free-list head: two write ports (one per
// dispatch slot) and one asynchronous read port for rollback.
module fl_ckpt
    import free_list_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     we,
    input  ROB_IDX_t waddr0,
    input  FL_PTR_t  wdata0,
    input  ROB_IDX_t waddr1,
    input  FL_PTR_t  wdata1,
    input  ROB_IDX_t raddr,
    output FL_PTR_t  rdata
);

    FL_PTR_t mem [NUM_ROB];

    // NOTE: this array is reset on purpose (a rollback to a never-written
    // slot must restore head 0), so it maps to flops rather than a RAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ROB; i++) mem[i] <= '0;
        end else if (we) begin
            // NOTE: non-blocking writes; on an address clash port 1 wins.
            mem[waddr0] <= wdata0;
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags: combinational 2-wide
// allocation, 2-wide reclaim at retire, checkpointed head for rollback.
module free_list
    import free_list_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    free_list_if.slave  bus
);

    PR_IDX_t fl [NUM_FL];
    FL_PTR_t head, tail;
    FL_PTR_t head_next, tail_next, head_pop, head_rb, pos1, tail1;
    FL_PTR_t free_cnt, npop, npush, room;
    logic    need0, need1, pop, rollback;
    logic    push0, push1, push0_ok, push1_ok, overflow;
    FL_ROB_OUT_t fl_out;

    // NOTE: every always_comb output gets a default first, so no latches.
    always_comb begin
        fl_out   = '0;
        need0    = bus.decoder.dest_idx[0] != ARCH_IDX_t'(ZERO_REG);
        need1    = bus.decoder.dest_idx[1] != ARCH_IDX_t'(ZERO_REG);
        npop     = FL_PTR_t'(need0) + FL_PTR_t'(need1);
        free_cnt = tail - head;
        pos1     = head + FL_PTR_t'(need0);
        head_pop = head + npop;

        fl_out.T_idx[0] = need0 ? fl[head[FL_W-1:0]] : PR_IDX_t'(ZERO_REG);
        fl_out.T_idx[1] = need1 ? fl[pos1[FL_W-1:0]] : PR_IDX_t'(ZERO_REG);

        // Tags pushed this cycle are not visible to this cycle's dispatch.
        bus.FL_valid = !bus.rollback_en && (free_cnt >= npop);
        pop          = bus.en && bus.dispatch_en && bus.FL_valid;
        rollback     = bus.en && bus.rollback_en;

        push0 = bus.en && bus.retire_en[0] && (bus.rob.Told_idx[0] != PR_IDX_t'(ZERO_REG));
        push1 = bus.en && bus.retire_en[1] && (bus.rob.Told_idx[1] != PR_IDX_t'(ZERO_REG));

        // Pushes beyond capacity are dropped rather than overwriting live tags.
        room     = FL_PTR_t'(NUM_FL) - free_cnt;
        push0_ok = push0 && (room != '0);
        push1_ok = push1 && (room > FL_PTR_t'(push0_ok));
        overflow = (push0 && !push0_ok) || (push1 && !push1_ok);
        npush    = FL_PTR_t'(push0_ok) + FL_PTR_t'(push1_ok);
        tail1    = tail + FL_PTR_t'(push0_ok);
        tail_next = tail + npush;

        head_next = head;
        if (rollback)  head_next = head_rb;
        else if (pop)  head_next = head_pop;
    end

    assign bus.fl         = fl_out;
    assign bus.free_count = free_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= FL_PTR_t'(NUM_FL);
            for (int i = 0; i < NUM_FL; i++) fl[i] <= PR_IDX_t'(NUM_PR - NUM_FL + i);
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (push0_ok) fl[tail[FL_W-1:0]]  <= bus.rob.Told_idx[0];
            if (push1_ok) fl[tail1[FL_W-1:0]] <= bus.rob.Told_idx[1];
        end
    end

    fl_ckpt u_fl_ckpt (
        .clock  (clock),
        .reset  (reset),
        .we     (pop),
        .waddr0 (bus.ROB_idx[0]),
        .wdata0 (pos1),
        .waddr1 (bus.ROB_idx[1]),
        .wdata1 (head_pop),
        .raddr  (bus.ROB_rollback_idx),
        .rdata  (head_rb)
    );

    overflow_a: assert property (@(posedge clock) disable iff (!reset) !overflow);

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: directed scenarios followed by randomized
// dispatch/retire/rollback traffic from a small in-flight ROB model.
module tb_free_list;
    import free_list_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    free_list_if bus();

    free_list u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit valid;
        int fc;
        int t0;
        int t1;
        bit k0;
        bit k1;
    } exp_t;

    typedef struct {
        int rob;
        int tag;
    } ent_t;

    exp_t exp_q[$];
    ent_t rob_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: every tag ever made free, in order, indexed by an
    // unbounded count; allocation and reclaim are just counters into it.
    int hist[int];
    int pops;
    int pushes;
    int ckpt_abs[NUM_ROB];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < NUM_FL; i++) hist[i] = NUM_PR - NUM_FL + i;
        pops   = 0;
        pushes = NUM_FL;
        for (int i = 0; i < NUM_ROB; i++) ckpt_abs[i] = 0;
        exp_q.delete();
    endfunction

    // Monitor: compares the DUT's combinational outputs mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (reset && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("fl_valid", int'(bus.FL_valid), int'(e.valid));
            check("free_count", int'(bus.free_count), e.fc);
            if (e.k0) check("t_idx0", int'(bus.fl.T_idx[0]), e.t0);
            if (e.k1) check("t_idx1", int'(bus.fl.T_idx[1]), e.t1);
        end
    end

    task automatic step(input bit en_i, input bit disp, input int d0, input int d1,
                        input int rob0, input int rob1, input bit [1:0] ret,
                        input int told0, input int told1, input bit rb, input int rb_idx,
                        output bit did_pop, output int tag0, output int tag1);
        exp_t e;
        bit   n0, n1;
        int   np, fc;
        bus.en               = en_i;
        bus.dispatch_en      = disp;
        bus.decoder.dest_idx[0] = ARCH_IDX_t'(d0);
        bus.decoder.dest_idx[1] = ARCH_IDX_t'(d1);
        bus.ROB_idx[0]       = ROB_IDX_t'(rob0);
        bus.ROB_idx[1]       = ROB_IDX_t'(rob1);
        bus.retire_en        = ret;
        bus.rob.Told_idx[0]  = PR_IDX_t'(told0);
        bus.rob.Told_idx[1]  = PR_IDX_t'(told1);
        bus.rollback_en      = rb;
        bus.ROB_rollback_idx = ROB_IDX_t'(rb_idx);

        n0 = (d0 != ZERO_REG);
        n1 = (d1 != ZERO_REG);
        np = int'(n0) + int'(n1);
        fc = pushes - pops;
        e.valid = !rb && (fc >= np);
        e.fc    = fc;
        e.k0    = !n0 || (pops < pushes);
        e.k1    = !n1 || (pops + int'(n0) < pushes);
        e.t0    = !n0 ? ZERO_REG : (e.k0 ? hist[pops] : 0);
        e.t1    = !n1 ? ZERO_REG : (e.k1 ? hist[pops + int'(n0)] : 0);
        exp_q.push_back(e);

        did_pop = 1'b0;
        tag0    = e.t0;
        tag1    = e.t1;
        if (en_i) begin
            if (ret[0] && told0 != ZERO_REG) begin hist[pushes] = told0; pushes++; end
            if (ret[1] && told1 != ZERO_REG) begin hist[pushes] = told1; pushes++; end
            if (rb) begin
                pops = ckpt_abs[rb_idx];
            end else if (disp && e.valid) begin
                ckpt_abs[rob0] = pops + int'(n0);
                ckpt_abs[rob1] = pops + np;
                pops += np;
                did_pop = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic disp_pair(input int d0, input int d1, input int rob0, input int rob1);
        bit p;
        int a, b;
        step(1, 1, d0, d1, rob0, rob1, 2'b00, ZERO_REG, ZERO_REG, 0, 0, p, a, b);
    endtask

    task automatic retire(input bit [1:0] ret, input int t0, input int t1);
        bit p;
        int a, b;
        step(1, 0, 1, 2, 0, 1, ret, t0, t1, 0, 0, p, a, b);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        bit p;
        int a, b, r;
        bit en_r, disp_r, rb_r;
        int nret, j, rb_idx, d0, d1, t0, t1, next_rob;
        bit [1:0] ret_r;

        bus.en = 1'b0; bus.dispatch_en = 1'b0; bus.decoder = '0; bus.ROB_idx = '0;
        bus.retire_en = '0; bus.rob = '0; bus.rollback_en = 1'b0; bus.ROB_rollback_idx = '0;
        @(posedge clock);
        #1;
        do_reset();

        // Reset state, one-sided allocations, retire of the zero register.
        disp_pair(1, 2, 0, 1);
        disp_pair(31, 4, 2, 3);
        retire(2'b11, 31, 7);
        disp_pair(31, 5, 4, 5);
        r = 6;
        while (pushes - pops >= 2) begin
            disp_pair(1, 2, r, (r + 1) % NUM_ROB);
            r = (r + 2) % NUM_ROB;
        end
        // One tag left: pair is refused; the tag freed now is not bypassed.
        step(1, 1, 1, 2, 8, 9, 2'b01, 40, ZERO_REG, 0, 0, p, a, b);
        disp_pair(1, 2, 8, 9);

        // Refill, then dispatch A, B, C and roll back to A.
        for (int k = 0; k < 5; k++) retire(2'b11, 50 + 2 * k, 51 + 2 * k);
        disp_pair(31, 1, 2, 3);
        disp_pair(2, 3, 4, 5);
        step(1, 1, 6, 7, 6, 7, 2'b00, ZERO_REG, ZERO_REG, 1, 3, p, a, b);
        disp_pair(6, 7, 6, 7);
        // Global stall holds state.
        step(0, 1, 8, 9, 8, 9, 2'b11, 60, 61, 0, 0, p, a, b);
        disp_pair(8, 9, 8, 9);

        // Reset with traffic on the bus, then roll back to a never-written slot.
        bus.dispatch_en = 1'b1;
        bus.retire_en   = 2'b11;
        do_reset();
        disp_pair(1, 2, 0, 1);
        step(1, 0, 1, 2, 2, 3, 2'b00, ZERO_REG, ZERO_REG, 1, 17, p, a, b);
        disp_pair(3, 4, 2, 3);

        // Random traffic; retired tags are the ones the ROB entry received.
        next_rob = 4;
        for (int cyc = 0; cyc < 700; cyc++) begin
            en_r = ($urandom_range(9) != 0);
            nret = $urandom_range(2);
            if (nret > rob_q.size()) nret = rob_q.size();
            ret_r = (nret == 2) ? 2'b11 : (nret == 1) ? 2'b01 : 2'b00;
            t0 = (nret >= 1) ? rob_q[0].tag : ZERO_REG;
            t1 = (nret == 2) ? rob_q[1].tag : ZERO_REG;
            rb_r   = 1'b0;
            rb_idx = 0;
            j      = 0;
            if (rob_q.size() > nret && $urandom_range(11) == 0) begin
                rb_r   = 1'b1;
                j      = $urandom_range(rob_q.size() - 1, nret);
                rb_idx = rob_q[j].rob;
            end
            disp_r = (rob_q.size() <= 28) && ($urandom_range(3) != 0);
            d0 = ($urandom_range(4) == 0) ? ZERO_REG : $urandom_range(30);
            d1 = ($urandom_range(4) == 0) ? ZERO_REG : $urandom_range(30);
            step(en_r, disp_r, d0, d1, next_rob, (next_rob + 1) % NUM_ROB, ret_r,
                 t0, t1, rb_r, rb_idx, p, a, b);
            if (en_r) begin
                if (rb_r) begin
                    while (rob_q.size() > j + 1) void'(rob_q.pop_back());
                    next_rob = (rb_idx + 1) % NUM_ROB;
                end
                for (int k = 0; k < nret; k++) void'(rob_q.pop_front());
                if (p) begin
                    rob_q.push_back('{rob: next_rob, tag: a});
                    rob_q.push_back('{rob: (next_rob + 1) % NUM_ROB, tag: b});
                    next_rob = (next_rob + 2) % NUM_ROB;
                end
            end
        end

        bus.en = 1'b0;
        @(negedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
